// File: rtl/ram_port_arb_if.sv
// Host-side and RAM-side signals of the shared RAM port arbiter.
// host_lock_i exists only when RAM_ARB_LOCK_EN is defined.
interface ram_port_arb_if #(
  parameter int unsigned NumHosts = 3
);
  logic [NumHosts-1:0]      host_req_i;
  logic [NumHosts-1:0]      host_gnt_o;
  logic [NumHosts-1:0]      host_we_i;
  logic [4*NumHosts-1:0]    host_be_i;
  logic [32*NumHosts-1:0]   host_addr_i;
  logic [32*NumHosts-1:0]   host_wdata_i;
  logic [NumHosts-1:0]      host_rvalid_o;
  logic [32*NumHosts-1:0]   host_rdata_o;
  logic [NumHosts-1:0]      host_err_o;
`ifdef RAM_ARB_LOCK_EN
  logic [NumHosts-1:0]      host_lock_i;
`endif
  logic                     ram_req_o;
  logic                     ram_we_o;
  logic [3:0]               ram_be_o;
  logic [31:0]              ram_addr_o;
  logic [31:0]              ram_wdata_o;
  logic                     ram_rvalid_i;
  logic [31:0]              ram_rdata_i;

  // Arbiter view.
  modport slave (
    input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
`ifdef RAM_ARB_LOCK_EN
    input  host_lock_i,
`endif
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rvalid_i, ram_rdata_i
  );

  // Environment view: hosts plus the RAM.
  modport master (
    output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
`ifdef RAM_ARB_LOCK_EN
    output host_lock_i,
`endif
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rvalid_i, ram_rdata_i
  );
endinterface

// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one 1-cycle-latency RAM port between NumHosts hosts.
// Optional bus locking is compiled in with `define RAM_ARB_LOCK_EN.
module ram_port_arb #(
  parameter int unsigned NumHosts = 3,
  parameter int unsigned Depth    = 128,
  parameter int unsigned LockMax  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ram_port_arb_if.slave bus
);
  localparam int unsigned IdxW      = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam logic [31:0] AddrLimit = 32'(Depth * 4);

  if (NumHosts < 2 || NumHosts > 8 || LockMax < 1) begin : gen_bad_param
    $error("ram_port_arb: unsupported NumHosts/LockMax");
  end

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (32'(i) == NumHosts - 1) ? '0 : i + 1'b1;
  endfunction

  logic [IdxW-1:0]     ptr_q;
  logic                resp_valid_q, resp_err_q, resp_we_q;
  logic [IdxW-1:0]     resp_owner_q;
  logic [NumHosts-1:0] eligible;
  logic                gnt_any;
  logic [IdxW-1:0]     gnt_idx, cand;
  logic                sel_we, sel_in_range, ram_req;
  logic [3:0]          sel_be;
  logic [31:0]         sel_addr, sel_wdata;

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_e;
  localparam int unsigned CntW = (LockMax > 1) ? $clog2(LockMax) : 1;

  lock_state_e     state_q;
  logic [IdxW-1:0] owner_q;
  logic [CntW-1:0] cnt_q;
  logic            lock_active;

  // The owner releasing its lock frees arbitration in that same cycle.
  assign lock_active = (state_q == LOCKED) && bus.host_lock_i[owner_q];

  always_comb begin
    eligible = bus.host_req_i;
    if (lock_active) begin
      for (int unsigned h = 0; h < NumHosts; h++) begin
        if (IdxW'(h) != owner_q) eligible[h] = 1'b0;
      end
    end
  end
`else
  assign eligible = bus.host_req_i;
`endif

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumHosts; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NumHosts);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst_i) gnt_any = 1'b0;
  end

  always_comb begin
    bus.host_gnt_o = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned h = 0; h < NumHosts; h++) begin
      if (gnt_any && gnt_idx == IdxW'(h)) begin
        bus.host_gnt_o[h] = 1'b1;
        sel_we    = bus.host_we_i[h];
        sel_be    = bus.host_be_i[4*h +: 4];
        sel_addr  = bus.host_addr_i[32*h +: 32];
        sel_wdata = bus.host_wdata_i[32*h +: 32];
      end
    end
  end

  assign sel_in_range = (sel_addr < AddrLimit);
  assign ram_req      = gnt_any && sel_in_range;

  always_comb begin
    bus.ram_req_o   = ram_req;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = '0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    if (ram_req) begin
      bus.ram_we_o    = sel_we;
      bus.ram_be_o    = sel_be;
      bus.ram_addr_o  = sel_addr;
      bus.ram_wdata_o = sel_wdata;
    end
  end

  // Gating by rst_i suppresses the response to a grant issued just before reset.
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    bus.host_rdata_o  = '0;
    if (resp_valid_q && !rst_i) begin
      for (int unsigned h = 0; h < NumHosts; h++) begin
        if (resp_owner_q == IdxW'(h)) begin
          bus.host_rvalid_o[h] = 1'b1;
          bus.host_err_o[h]    = resp_err_q;
          if (!resp_err_q && !resp_we_q) bus.host_rdata_o[32*h +: 32] = bus.ram_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_owner_q <= '0;
`ifdef RAM_ARB_LOCK_EN
      state_q      <= IDLE;
      owner_q      <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      resp_valid_q <= gnt_any;
      if (gnt_any) begin
        resp_owner_q <= gnt_idx;
        resp_err_q   <= !sel_in_range;
        resp_we_q    <= sel_we;
      end
`ifdef RAM_ARB_LOCK_EN
      if (lock_active) begin
        // Forced unlock moves the pointer past the owner so it cannot relock at once.
        if (cnt_q == CntW'(LockMax - 1)) begin
          state_q <= IDLE;
          ptr_q   <= next_idx(owner_q);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        if (gnt_any) ptr_q <= next_idx(gnt_idx);
        if (gnt_any && bus.host_lock_i[gnt_idx]) begin
          state_q <= LOCKED;
          owner_q <= gnt_idx;
          cnt_q   <= '0;
        end else begin
          state_q <= IDLE;
        end
      end
`else
      if (gnt_any) ptr_q <= next_idx(gnt_idx);
`endif
    end
  end

  RamRvalidMatch: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.ram_rvalid_i == (resp_valid_q & ~resp_err_q));

endmodule
